button_debounce: RTL and testbench

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/button_debounce_pkg.sv | 28 ++
 rtl/button_debounce_if.sv | 64 ++++++
 rtl/button_debounce_channel.sv | 125 ++++++++++++
 rtl/button_debounce.sv | 81 ++++++++
 tb/tb_button_debounce.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/button_debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : button_debounce_pkg
//  Purpose : Shared types and constants for the button debouncer: the
//            per-channel FSM state encoding, the default debounce interval
//            and the width of each per-channel press counter.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package button_debounce_pkg;

    // Per-channel debounce FSM. STABLE_* are accepted levels; CHECK_* are
    // tentative moves towards the opposite level.
    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        CHECK_HIGH  = 2'd1,
        STABLE_HIGH = 2'd2,
        CHECK_LOW   = 2'd3
    } db_state_e;

    // Default number of consecutive stable samples needed to accept a change.
    localparam int unsigned C_DEFAULT_DEBOUNCE_CYCLES = 50000;

    // Width of each per-channel press counter (wraps, never saturates).
    localparam int unsigned C_PRESS_CNT_WIDTH = 8;

endpackage : button_debounce_pkg
`default_nettype wire

// File: rtl/button_debounce_if.sv
`default_nettype none
// ============================================================================
//  Module  : button_debounce_if / debounce_ch_if
//  Purpose : button_debounce_if bundles the complete pin set of the
//            debouncer block (host drives raw levels and clear mask, block
//            returns levels, pulses, flags, counters and interrupt).
//            debounce_ch_if is the per-channel link between one
//            debounce_channel and the enclosing button_debounce.
//  Ports   : button_debounce_if
//              buttons_raw, clr_i           host -> block
//              buttons_db, rise_o, fall_o,
//              event_flags, press_cnt, irq_o block -> host
//            debounce_ch_if
//              raw                          top -> channel
//              db, rise, fall, rise_evt,
//              press_cnt                    channel -> top
//  Rev     : 1.0  initial release
// ============================================================================
interface button_debounce_if #(
    parameter int NUM_BUTTONS = 3
);
    import button_debounce_pkg::*;

    logic [NUM_BUTTONS-1:0]                   buttons_raw;
    logic [NUM_BUTTONS-1:0]                   clr_i;
    logic [NUM_BUTTONS-1:0]                   buttons_db;
    logic [NUM_BUTTONS-1:0]                   rise_o;
    logic [NUM_BUTTONS-1:0]                   fall_o;
    logic [NUM_BUTTONS-1:0]                   event_flags;
    logic [C_PRESS_CNT_WIDTH*NUM_BUTTONS-1:0] press_cnt;
    logic                                     irq_o;

    modport master (
        output buttons_raw, clr_i,
        input  buttons_db, rise_o, fall_o, event_flags, press_cnt, irq_o
    );

    modport slave (
        input  buttons_raw, clr_i,
        output buttons_db, rise_o, fall_o, event_flags, press_cnt, irq_o
    );
endinterface : button_debounce_if

interface debounce_ch_if;
    import button_debounce_pkg::*;

    logic                         raw;
    logic                         db;
    logic                         rise;
    logic                         fall;
    logic                         rise_evt;   // next-cycle rise, lets the top set flags on the same edge as rise
    logic [C_PRESS_CNT_WIDTH-1:0] press_cnt;

    modport chan (
        input  raw,
        output db, rise, fall, rise_evt, press_cnt
    );

    modport host (
        output raw,
        input  db, rise, fall, rise_evt, press_cnt
    );
endinterface : debounce_ch_if
`default_nettype wire

// File: rtl/button_debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module  : debounce_channel
//  Purpose : One debounce channel: 2-flop synchronizer, four-state stability
//            FSM with a stability counter, registered rise/fall pulses and an
//            8-bit wrapping press counter.
//  Ports   : clk      clock
//            reset_n  asynchronous active-low reset
//            ch       debounce_ch_if.chan (raw in; db, rise, fall, rise_evt,
//                     press_cnt out)
//  Rev     : 1.0  initial release
// ============================================================================
module debounce_channel
    import button_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = C_DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  wire logic   clk,
    input  wire logic   reset_n,
    debounce_ch_if.chan ch
);

    // Terminal count: the change is accepted on the sample that finds the
    // counter here while the input still matches the target level.
    localparam logic [CNT_WIDTH-1:0] C_CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                         sync1_q;
    logic                         sync2_q;
    db_state_e                    state_q, state_d;
    logic [CNT_WIDTH-1:0]         cnt_q,   cnt_d;
    logic                         db_q,    db_d;
    logic                         rise_q,  rise_d;
    logic                         fall_q,  fall_d;
    logic [C_PRESS_CNT_WIDTH-1:0] press_q, press_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            press_q <= '0;
        end else begin
            sync1_q <= ch.raw;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            press_q <= press_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        case (state_q)
            STABLE_LOW: begin
                if (sync2_q) begin
                    state_d = CHECK_HIGH;
                    cnt_d   = '0;
                end
            end
            CHECK_HIGH: begin
                if (sync2_q) begin
                    if (cnt_q == C_CNT_LAST) begin
                        state_d = STABLE_HIGH;
                        cnt_d   = '0;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end else begin
                    // Bounce: fall back silently to the accepted level.
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end
            end
            STABLE_HIGH: begin
                if (!sync2_q) begin
                    state_d = CHECK_LOW;
                    cnt_d   = '0;
                end
            end
            CHECK_LOW: begin
                if (!sync2_q) begin
                    if (cnt_q == C_CNT_LAST) begin
                        state_d = STABLE_LOW;
                        cnt_d   = '0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end else begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
            end
        endcase

        // The accepted level stays high while a fall is only being checked.
        db_d    = (state_d == STABLE_HIGH) || (state_d == CHECK_LOW);
        press_d = press_q + C_PRESS_CNT_WIDTH'(rise_d);
    end

    assign ch.db        = db_q;
    assign ch.rise      = rise_q;
    assign ch.fall      = fall_q;
    assign ch.rise_evt  = rise_d;
    assign ch.press_cnt = press_q;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module  : button_debounce
//  Purpose : NUM_BUTTONS independent debounce channels plus sticky press
//            flags and a level interrupt.
//  Ports   : clk          clock
//            reset_n      asynchronous active-low reset
//            buttons_raw  unsynchronized pad levels
//            clr_i        one-cycle mask clearing event_flags bits
//            buttons_db   debounced levels
//            rise_o       one-cycle pulse on accepted 0->1
//            fall_o       one-cycle pulse on accepted 1->0
//            event_flags  sticky press flags
//            press_cnt    8-bit press counter per channel, channel i at [8i+7:8i]
//            irq_o        OR of event_flags
//  Rev     : 1.0  initial release
// ============================================================================
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int unsigned NUM_BUTTONS     = 3,
    parameter int unsigned DEBOUNCE_CYCLES = C_DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  wire logic                                     clk,
    input  wire logic                                     reset_n,
    input  wire logic [NUM_BUTTONS-1:0]                   buttons_raw,
    input  wire logic [NUM_BUTTONS-1:0]                   clr_i,
    output logic      [NUM_BUTTONS-1:0]                   buttons_db,
    output logic      [NUM_BUTTONS-1:0]                   rise_o,
    output logic      [NUM_BUTTONS-1:0]                   fall_o,
    output logic      [NUM_BUTTONS-1:0]                   event_flags,
    output logic      [C_PRESS_CNT_WIDTH*NUM_BUTTONS-1:0] press_cnt,
    output logic                                          irq_o
);

    logic [NUM_BUTTONS-1:0] rise_evt;
    logic [NUM_BUTTONS-1:0] event_flags_q, event_flags_d;

    generate
        for (genvar g = 0; g < int'(NUM_BUTTONS); g++) begin : g_channel
            debounce_ch_if ch_if ();

            assign ch_if.raw = buttons_raw[g];

            debounce_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_WIDTH       (CNT_WIDTH)
            ) u_channel (
                .clk     (clk),
                .reset_n (reset_n),
                .ch      (ch_if)
            );

            assign buttons_db[g] = ch_if.db;
            assign rise_o[g]     = ch_if.rise;
            assign fall_o[g]     = ch_if.fall;
            assign rise_evt[g]   = ch_if.rise_evt;
            assign press_cnt[g*C_PRESS_CNT_WIDTH +: C_PRESS_CNT_WIDTH] = ch_if.press_cnt;
        end
    endgenerate

    // Flags are set from the channel's next-cycle rise so they update on the
    // same edge as rise_o; OR-ing the set after the clear makes set win.
    always_comb begin
        event_flags_d = (event_flags_q & ~clr_i) | rise_evt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            event_flags_q <= '0;
        end else begin
            event_flags_q <= event_flags_d;
        end
    end

    assign event_flags = event_flags_q;
    assign irq_o       = |event_flags_q;

endmodule : button_debounce
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
//  Module  : tb_button_debounce
//  Purpose : Self-checking bench for button_debounce (3 channels,
//            DEBOUNCE_CYCLES=4). Stimulus pushes expected outputs from a
//            sample-history reference model into a queue; a monitor pops
//            and compares every cycle. Directed scenarios add constant
//            checks on latency, glitch rejection, wrap, clear priority,
//            reset abort and simultaneous events.
//  Ports   : none
//  Rev     : 1.0  initial release
// ============================================================================
module tb_button_debounce;

    localparam int NB = 3;
    localparam int N  = 4;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    button_debounce_if #(.NUM_BUTTONS(NB)) bus ();

    button_debounce #(
        .NUM_BUTTONS     (NB),
        .DEBOUNCE_CYCLES (N),
        .CNT_WIDTH       (CW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .buttons_raw (bus.buttons_raw),
        .clr_i       (bus.clr_i),
        .buttons_db  (bus.buttons_db),
        .rise_o      (bus.rise_o),
        .fall_o      (bus.fall_o),
        .event_flags (bus.event_flags),
        .press_cnt   (bus.press_cnt),
        .irq_o       (bus.irq_o)
    );

    typedef struct {
        logic [2:0]  db;
        logic [2:0]  rise;
        logic [2:0]  fall;
        logic [2:0]  flags;
        logic [23:0] cnt;
        logic        irq;
    } exp_t;

    exp_t q[$];

    int checks   = 0;
    int failures = 0;

    // Reference model: a level is accepted once the N+1 synchronized samples
    // ending two edges ago all differ from the current accepted level.
    logic [2:0] m_db;
    logic [2:0] m_flags;
    logic [7:0] m_cnt [NB];
    logic [2:0] hist[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_db    = '0;
        m_flags = '0;
        for (int c = 0; c < NB; c++) m_cnt[c] = '0;
        hist.delete();
    endtask

    // Drive inputs for the next edge, predict its outcome, then advance to
    // just after that edge.
    task automatic tick(input logic [2:0] raw, input logic [2:0] clr);
        exp_t       e;
        logic [2:0] rs;
        logic [2:0] fl;
        bit         diff;
        bus.buttons_raw = raw;
        bus.clr_i       = clr;
        hist.push_back(raw);
        if (hist.size() > N + 3) void'(hist.pop_front());
        rs = '0;
        fl = '0;
        if (hist.size() == N + 3) begin
            for (int c = 0; c < NB; c++) begin
                diff = 1'b1;
                for (int j = 0; j <= N; j++) begin
                    if (hist[j][c] == m_db[c]) diff = 1'b0;
                end
                if (diff) begin
                    m_db[c] = ~m_db[c];
                    if (m_db[c]) rs[c] = 1'b1;
                    else         fl[c] = 1'b1;
                end
            end
        end
        m_flags = (m_flags & ~clr) | rs;
        for (int c = 0; c < NB; c++) begin
            if (rs[c]) m_cnt[c] = m_cnt[c] + 8'd1;
        end
        e.db    = m_db;
        e.rise  = rs;
        e.fall  = fl;
        e.flags = m_flags;
        e.cnt   = {m_cnt[2], m_cnt[1], m_cnt[0]};
        e.irq   = |m_flags;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset_check(input string tag);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk({tag, "_db"},    32'(bus.buttons_db),  32'd0);
        chk({tag, "_rise"},  32'(bus.rise_o),      32'd0);
        chk({tag, "_fall"},  32'(bus.fall_o),      32'd0);
        chk({tag, "_flags"}, 32'(bus.event_flags), 32'd0);
        chk({tag, "_cnt"},   32'(bus.press_cnt),   32'd0);
        chk({tag, "_irq"},   32'(bus.irq_o),       32'd0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        reset_n = 1'b1;
    endtask

    task automatic run_watch(input logic [2:0] raw, input int ch, input int nedges,
                             input int clr_edge, input logic [2:0] clr,
                             output int rise_edge, output int rise_cnt);
        rise_edge = 0;
        rise_cnt  = 0;
        for (int e = 1; e <= nedges; e++) begin
            tick(raw, (e == clr_edge) ? clr : 3'b000);
            if (bus.rise_o[ch]) begin
                rise_cnt++;
                if (rise_edge == 0) rise_edge = e;
            end
        end
    endtask

    // Scoreboard monitor: the DUT presents a full output set every cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_db",    32'(bus.buttons_db),  32'(e.db));
                chk("sb_rise",  32'(bus.rise_o),      32'(e.rise));
                chk("sb_fall",  32'(bus.fall_o),      32'(e.fall));
                chk("sb_flags", 32'(bus.event_flags), 32'(e.flags));
                chk("sb_cnt",   32'(bus.press_cnt),   32'(e.cnt));
                chk("sb_irq",   32'(bus.irq_o),       32'(e.irq));
            end
        end
    end

    initial begin : stimulus
        int         re, rc, n_hi, n_rise, first_all;
        int         rem [NB];
        logic [2:0] r;
        logic [2:0] clr;

        reset_n         = 1'b0;
        bus.buttons_raw = '0;
        bus.clr_i       = '0;
        model_reset();
        @(posedge clk); #2;
        do_reset_check("por");

        // Scenario 1: clean press on channel 0.
        run_watch(3'b001, 0, 10, 0, 3'b000, re, rc);
        chk("s1_rise_edge",  32'(re), 32'd7);
        chk("s1_rise_count", 32'(rc), 32'd1);
        chk("s1_db",         32'(bus.buttons_db),     32'b001);
        chk("s1_flags",      32'(bus.event_flags),    32'b001);
        chk("s1_cnt0",       32'(bus.press_cnt[7:0]), 32'd1);
        chk("s1_irq",        32'(bus.irq_o),          32'd1);

        // Scenario 2: 3-edge glitch on channel 1.
        n_hi   = 0;
        n_rise = 0;
        for (int e = 1; e <= 13; e++) begin
            tick((e <= 3) ? 3'b011 : 3'b001, 3'b000);
            if (bus.buttons_db[1]) n_hi++;
            if (bus.rise_o[1])     n_rise++;
        end
        chk("s2_db1_high_cycles", 32'(n_hi),   32'd0);
        chk("s2_rise1_count",     32'(n_rise), 32'd0);
        chk("s2_flag1",           32'(bus.event_flags[1]), 32'd0);

        tick(3'b001, 3'b001);
        chk("clr_flags", 32'(bus.event_flags), 32'd0);
        chk("clr_irq",   32'(bus.irq_o),       32'd0);

        // Scenario 4: clear coinciding with a new rise, then a later clear.
        run_watch(3'b000, 0, 10, 0, 3'b000, re, rc);
        chk("s4_db_released", 32'(bus.buttons_db[0]), 32'd0);
        run_watch(3'b001, 0, 9, 7, 3'b001, re, rc);
        chk("s4_rise_edge",  32'(re), 32'd7);
        chk("s4_flag_kept",  32'(bus.event_flags[0]), 32'd1);
        chk("s4_cnt0",       32'(bus.press_cnt[7:0]), 32'd2);
        tick(3'b001, 3'b001);
        chk("s4_flag_cleared", 32'(bus.event_flags[0]), 32'd0);
        chk("s4_irq_dropped",  32'(bus.irq_o),          32'd0);

        // Scenario 3: 256 presses on channel 2 wrap its counter.
        do_reset_check("s3");
        n_rise = 0;
        for (int p = 0; p < 256; p++) begin
            for (int e = 0; e < 8; e++) begin
                tick(3'b100, 3'b000);
                if (bus.rise_o[2]) n_rise++;
            end
            for (int e = 0; e < 8; e++) tick(3'b000, 3'b000);
        end
        chk("s3_rise_count", 32'(n_rise), 32'd256);
        chk("s3_cnt2_wrap",  32'(bus.press_cnt[23:16]), 32'd0);
        chk("s3_flag2",      32'(bus.event_flags[2]),   32'd1);

        // Scenario 5: reset two edges into CHECK_HIGH, button held through it.
        for (int e = 0; e < 5; e++) tick(3'b001, 3'b000);
        do_reset_check("s5");
        run_watch(3'b001, 0, 10, 0, 3'b000, re, rc);
        chk("s5_rise_edge",  32'(re), 32'd7);
        chk("s5_rise_count", 32'(rc), 32'd1);

        // Scenario 6: all three channels rise together.
        bus.buttons_raw = 3'b000;
        do_reset_check("s6");
        first_all = 0;
        for (int e = 1; e <= 10; e++) begin
            tick(3'b111, 3'b000);
            if (bus.rise_o == 3'b111 && first_all == 0) first_all = e;
        end
        chk("s6_all_rise_edge", 32'(first_all), 32'd7);
        chk("s6_cnts",          32'(bus.press_cnt), 32'h010101);
        chk("s6_flags",         32'(bus.event_flags), 32'b111);

        // Random phase: random hold lengths straddling the debounce window.
        r = 3'b111;
        for (int c = 0; c < NB; c++) rem[c] = 0;
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < NB; c++) begin
                if (rem[c] == 0) begin
                    r[c]   = ~r[c];
                    rem[c] = $urandom_range(1, 12);
                end else begin
                    rem[c]--;
                end
            end
            clr = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            tick(r, clr);
        end

        chk("scoreboard_drain", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_button_debounce
`default_nettype wire
